// File: rtl/dds_pkg.sv
// Shared definitions for the DDS signal path: default widths, table size and
// the configuration handshake state encoding.
package dds_pkg;

  localparam int ACC_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int TABLE_SIZE     = 1 << ADDR_WIDTH_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/dds_valid_delay.sv
// Delays a valid strobe by LATENCY cycles so it lines up with registered
// ROM read data. Usable by any consumer of the waveform tables.
module dds_valid_delay #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [LATENCY-1:0] sr;

  if (LATENCY == 1) begin : g_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= din;
    end
  end else begin : g_chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= {sr[LATENCY-2:0], din};
    end
  end

  assign dout = sr[LATENCY-1];

endmodule

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator and ROM address generator with a valid/ready
// configuration port that applies updates immediately or at the next wrap.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_sync,
  input  logic [ACC_WIDTH-1:0]  cfg_fword,
  input  logic [ADDR_WIDTH-1:0] cfg_pword,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  addr_valid,
  output logic                  data_valid,
  output logic                  cycle_start,
  output logic                  cfg_pending
);

  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  fword_act, fword_shd;
  logic [ADDR_WIDTH-1:0] pword_act, pword_shd;
  cfg_state_e            state;

  logic [ACC_WIDTH:0]    sum;
  logic                  wrap;
  logic [ADDR_WIDTH-1:0] next_addr;

  // The carry out of the extended add marks the end of a waveform period.
  assign sum       = {1'b0, acc} + {1'b0, fword_act};
  assign wrap      = sum[ACC_WIDTH];
  assign next_addr = sum[ACC_WIDTH-1 -: ADDR_WIDTH] + pword_act;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      rom_addr    <= '0;
      addr_valid  <= 1'b0;
      cycle_start <= 1'b0;
    end else if (clr) begin
      acc         <= '0;
      rom_addr    <= pword_act;
      addr_valid  <= en;
      cycle_start <= 1'b0;
    end else if (en) begin
      acc         <= sum[ACC_WIDTH-1:0];
      rom_addr    <= next_addr;
      addr_valid  <= 1'b1;
      cycle_start <= wrap;
    end else begin
      addr_valid  <= 1'b0;
      cycle_start <= 1'b0;
    end
  end

  // Active words change only after the add that used them, so a wrap-time
  // update never produces a partial period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fword_act   <= '0;
      pword_act   <= '0;
      fword_shd   <= '0;
      pword_shd   <= '0;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_valid && cfg_sync) begin
            fword_shd   <= cfg_fword;
            pword_shd   <= cfg_pword;
            state       <= PEND;
            cfg_ready   <= 1'b0;
            cfg_pending <= 1'b1;
          end else if (cfg_valid) begin
            fword_act <= cfg_fword;
            pword_act <= cfg_pword;
          end
        end
        PEND: begin
          // A zero tuning word never wraps, so release the update at once.
          if ((en && wrap) || clr || (fword_act == '0)) begin
            fword_act   <= fword_shd;
            pword_act   <= pword_shd;
            state       <= IDLE;
            cfg_ready   <= 1'b1;
            cfg_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dds_valid_delay #(
    .LATENCY(ROM_LATENCY)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (addr_valid),
    .dout (data_valid)
  );

endmodule

// File: tb/tb_dds_phase_acc.sv
// Directed bench for dds_phase_acc: wrap-aligned updates, phase offset,
// zero tuning word, reset during a pending update, en gating and clear.
module tb_dds_phase_acc;
  import dds_pkg::*;

  localparam int LAT = 2;

  logic        clk;
  logic        tb_rst;
  logic        en;
  logic        clr;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_sync;
  logic [31:0] cfg_fword;
  logic [9:0]  cfg_pword;
  logic [9:0]  rom_addr;
  logic        addr_valid;
  logic        data_valid;
  logic        cycle_start;
  logic        cfg_pending;

  int          tests;
  int          failed;
  logic [4:0]  hist;

  dds_phase_acc #(
    .ACC_WIDTH   (32),
    .ADDR_WIDTH  (10),
    .ROM_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (tb_rst),
    .en          (en),
    .clr         (clr),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sync    (cfg_sync),
    .cfg_fword   (cfg_fword),
    .cfg_pword   (cfg_pword),
    .rom_addr    (rom_addr),
    .addr_valid  (addr_valid),
    .data_valid  (data_valid),
    .cycle_start (cycle_start),
    .cfg_pending (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare the registered outputs against the model.
  task automatic step(input string tag, input int ea, input logic eav, input logic ecs);
    @(negedge clk);
    hist = {hist[3:0], eav};
    check({tag, ".addr"},  32'(rom_addr),    32'(ea % TABLE_SIZE));
    check({tag, ".av"},    32'(addr_valid),  32'(eav));
    check({tag, ".cs"},    32'(cycle_start), 32'(ecs));
    check({tag, ".dv"},    32'(data_valid),  32'(hist[LAT]));
  endtask

  task automatic check_fsm(input string tag, input logic ready, input logic pending);
    check({tag, ".ready"},   32'(cfg_ready),   32'(ready));
    check({tag, ".pending"}, 32'(cfg_pending), 32'(pending));
  endtask

  task automatic set_cfg(input logic v, input logic s, input logic [31:0] f, input logic [9:0] p);
    cfg_valid = v;
    cfg_sync  = s;
    cfg_fword = f;
    cfg_pword = p;
  endtask

  initial begin
    int a;
    tests     = 0;
    failed    = 0;
    hist      = '0;
    tb_rst    = 1'b1;
    en        = 1'b0;
    clr       = 1'b0;
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.addr", 32'(rom_addr), 32'd0);
    check("rst.av",   32'(addr_valid), 32'd0);
    check("rst.dv",   32'(data_valid), 32'd0);
    check("rst.cs",   32'(cycle_start), 32'd0);
    check_fsm("rst", 1'b1, 1'b0);
    tb_rst = 1'b0;

    // Step 1: immediate config, one address per cycle, wrap at 0.
    set_cfg(1'b1, 1'b0, 32'h0040_0000, 10'd0);
    step("s1.cfg", 0, 1'b0, 1'b0);
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);
    en = 1'b1;
    for (int k = 1; k <= 1024; k++) step("s1.run", k, 1'b1, k == 1024);

    // Step 2: sync update issued at address 500, applied at the wrap.
    for (int k = 1; k <= 500; k++) step("s2.pre", k, 1'b1, 1'b0);
    set_cfg(1'b1, 1'b1, 32'h0080_0000, 10'd0);
    step("s2.acc", 501, 1'b1, 1'b0);
    check_fsm("s2.acc", 1'b0, 1'b1);
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);
    for (int k = 502; k <= 1024; k++) begin
      step("s2.wait", k, 1'b1, k == 1024);
      check_fsm("s2.wait", k == 1024, k < 1024);
    end
    step("s2.new", 2, 1'b1, 1'b0);
    step("s2.new", 4, 1'b1, 1'b0);
    step("s2.new", 6, 1'b1, 1'b0);

    // Step 3: phase offset 256; the wrap-cycle add still uses the old words.
    set_cfg(1'b1, 1'b0, 32'h0040_0000, 10'd256);
    step("s3.cfg", 8, 1'b1, 1'b0);
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);
    for (a = 9; a <= 1024; a++) step("s3.run", a + 256, 1'b1, a == 1024);

    // Step 4: zero tuning word freezes the address; sync update exits at once.
    set_cfg(1'b1, 1'b0, 32'h0, 10'd256);
    step("s4.zero", 257, 1'b1, 1'b0);
    set_cfg(1'b1, 1'b1, 32'h0040_0000, 10'd10);
    step("s4.pend", 257, 1'b1, 1'b0);
    check_fsm("s4.pend", 1'b0, 1'b1);
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);
    step("s4.exit", 257, 1'b1, 1'b0);
    check_fsm("s4.exit", 1'b1, 1'b0);
    step("s4.new", 12, 1'b1, 1'b0);

    // Step 5: reset while a sync update waits near address 700.
    for (a = 3; a <= 690; a++) step("s5.pre", a + 10, 1'b1, 1'b0);
    set_cfg(1'b1, 1'b1, 32'h0080_0000, 10'd5);
    step("s5.pend", 701, 1'b1, 1'b0);
    check_fsm("s5.pend", 1'b0, 1'b1);
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);
    tb_rst = 1'b1;
    #1;
    check("s5.rst.addr", 32'(rom_addr), 32'd0);
    check("s5.rst.av",   32'(addr_valid), 32'd0);
    check("s5.rst.dv",   32'(data_valid), 32'd0);
    check("s5.rst.cs",   32'(cycle_start), 32'd0);
    check_fsm("s5.rst", 1'b1, 1'b0);
    @(negedge clk);
    tb_rst = 1'b0;
    hist   = '0;
    step("s5.post", 0, 1'b1, 1'b0);
    check_fsm("s5.post", 1'b1, 1'b0);
    step("s5.post", 0, 1'b1, 1'b0);

    // Step 6: en toggling, then clr together with a new config.
    en = 1'b0;
    set_cfg(1'b1, 1'b0, 32'h0040_0000, 10'd3);
    step("s6.cfg", 0, 1'b0, 1'b0);
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);
    a = 0;
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0);
      if (en) a++;
      step("s6.tog", a + 3, en, 1'b0);
    end
    en  = 1'b1;
    clr = 1'b1;
    set_cfg(1'b1, 1'b0, 32'h0080_0000, 10'd3);
    step("s6.clr", 3, 1'b1, 1'b0);
    clr = 1'b0;
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);
    step("s6.new", 5, 1'b1, 1'b0);
    step("s6.new", 7, 1'b1, 1'b0);

    // clr releases a pending update without a wrap.
    set_cfg(1'b1, 1'b1, 32'h0040_0000, 10'd3);
    step("s6.pend", 9, 1'b1, 1'b0);
    check_fsm("s6.pend", 1'b0, 1'b1);
    set_cfg(1'b0, 1'b0, 32'h0, 10'd0);
    clr = 1'b1;
    en  = 1'b0;
    step("s6.pclr", 3, 1'b0, 1'b0);
    check_fsm("s6.pclr", 1'b1, 1'b0);
    clr = 1'b0;
    en  = 1'b1;
    step("s6.after", 4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
